// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encodings and requester indices for mem_arbiter.
package mem_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic REQ_IMEM = 1'b0;
  localparam logic REQ_DMEM = 1'b1;
  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; pointer moves away from the requester just served.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic       gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    ptr_d = done ? ~done_id : ptr_q;
    gnt   = &req ? ptr_q : req[1];
  end
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) ptr_q <= REQ_DMEM;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction/data cache requests onto one RAM port.
// Define MEM_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC cycles without mem_ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_rw,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [DATA_W-1:0]   req_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_MemRead,
  output logic                mem_MemWrite,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                arb_timeout
);
  logic [1:0]        state_q, state_d;
  logic              id_q, id_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              gnt, take, fin, to_hit;

  rr_arbiter2 u_rr (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .req     (req_valid),
    .done    (state_q == DONE),
    .done_id (id_q),
    .gnt     (gnt)
  );

  assign take = (state_q == IDLE) && |req_valid;
  assign fin  = (state_q == BUSY) && (mem_ready || to_hit);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  always_comb begin
    to_hit = (state_q == BUSY) && !mem_ready && (cnt_q == CW'(TIMEOUT_CYC - 1));
    cnt_d  = take ? '0 : (state_q == BUSY) ? cnt_q + 1'b1 : cnt_q;
    to_d   = take ? 1'b0 : fin ? to_hit : to_q;
  end
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  assign arb_timeout = (state_q == DONE) && to_q;
`else
  assign to_hit      = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  always_comb begin
    state_d = take ? BUSY : fin ? DONE : (state_q == DONE) ? IDLE : state_q;
    id_d    = take ? gnt : id_q;
    rw_d    = take ? req_rw[gnt] : rw_q;
    addr_d  = take ? (gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0]) : addr_q;
    wdata_d = take ? (gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0]) : wdata_q;
    rdata_d = fin ? (mem_ready ? mem_rdata : '0) : rdata_q;
  end

  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      state_q <= IDLE;
      id_q    <= REQ_IMEM;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end

  assign req_ready    = (state_q == DONE) ? onehot2(id_q) : 2'b00;
  assign req_rdata    = rdata_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_MemRead  = (state_q == BUSY) && !rw_q;
  assign mem_MemWrite = (state_q == BUSY) && rw_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT_CYC=4).
module tb_mem_arbiter;
  logic        iCLK = 1'b0, iRST_n = 1'b0;
  logic [1:0]  req_valid = '0, req_rw = '0, req_ready;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [31:0] req_rdata, mem_addr, mem_wdata, mem_rdata = '0;
  logic        mem_MemRead, mem_MemWrite, mem_ready = 1'b0, arb_timeout;
  int pass = 0, total = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .req_rdata(req_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_timeout(arb_timeout)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST_n = 1'b0; req_valid = '0; req_rw = '0; mem_ready = 1'b0;
    tick(); tick();
    iRST_n = 1'b1;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; req_valid = 2'b11; mem_ready = 1'b1;
    req_addr = {32'h11, 32'h22}; tick();
    total++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", req_ready); else pass++;
    total++; if ({mem_MemRead, mem_MemWrite, arb_timeout} !== 3'b000) $display("FAIL rst_strobes: got %b expected 000", {mem_MemRead, mem_MemWrite, arb_timeout}); else pass++;
    total++; if (mem_addr !== 32'h0 || req_rdata !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL rst_data: got %h/%h/%h expected 0", mem_addr, req_rdata, mem_wdata); else pass++;
    req_valid = 2'b00; iRST_n = 1'b1;
    tick(); tick();
    total++; if ({req_ready, mem_MemRead, mem_MemWrite} !== 4'b0) $display("FAIL idle_mem_ready_ignored: got %b expected 0000", {req_ready, mem_MemRead, mem_MemWrite}); else pass++;
    mem_ready = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    req_valid = 2'b01; req_rw = 2'b00; req_addr[31:0] = 32'h40;
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    total++; if (mem_MemRead !== 1'b1 || mem_addr !== 32'h40 || req_ready !== 2'b00) $display("FAIL read_busy: got rd=%b addr=%h rdy=%b expected 1/40/00", mem_MemRead, mem_addr, req_ready); else pass++;
    tick();
    total++; if (req_ready !== 2'b01 || req_rdata !== 32'hDEADBEEF) $display("FAIL read_done: got rdy=%b data=%h expected 01/deadbeef", req_ready, req_rdata); else pass++;
    total++; if (mem_MemRead !== 1'b0) $display("FAIL read_strobe_done: got %b expected 0", mem_MemRead); else pass++;
    req_valid = 2'b00; mem_rdata = 32'h0;
    tick();
    total++; if (req_ready !== 2'b00 || req_rdata !== 32'hDEADBEEF) $display("FAIL read_hold: got rdy=%b data=%h expected 00/deadbeef", req_ready, req_rdata); else pass++;
    tick();
    total++; if (mem_MemRead !== 1'b0) $display("FAIL read_no_dup: got %b expected 0", mem_MemRead); else pass++;
    mem_ready = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    logic [31:0] ea;
    do_reset();
    req_valid = 2'b11; req_rw = 2'b00; req_addr = {32'h200, 32'h100}; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b10 : 2'b01;
      ea  = (k % 2 == 0) ? 32'h200 : 32'h100;
      for (int n = 0; n < 10; n++) begin
        tick();
        if (req_ready != 2'b00) break;
      end
      total++; if (req_ready !== exp || mem_addr !== ea) $display("FAIL contention_%0d: got rdy=%b addr=%h expected %b/%h", k, req_ready, mem_addr, exp, ea); else pass++;
    end
    req_valid = 2'b00; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_write_wait();
    do_reset();
    req_valid = 2'b10; req_rw = 2'b10; req_addr[63:32] = 32'h80; req_wdata[63:32] = 32'h12345678;
    tick();
    req_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      total++; if (mem_MemWrite !== 1'b1 || mem_MemRead !== 1'b0 || mem_addr !== 32'h80 || mem_wdata !== 32'h12345678 || req_ready !== 2'b00) $display("FAIL write_busy_%0d: got wr=%b rd=%b addr=%h wd=%h rdy=%b expected 1/0/80/12345678/00", c, mem_MemWrite, mem_MemRead, mem_addr, mem_wdata, req_ready); else pass++;
      if (c == 2) mem_ready = 1'b1;
      tick();
    end
    total++; if (req_ready !== 2'b10 || mem_MemWrite !== 1'b0) $display("FAIL write_done: got rdy=%b wr=%b expected 10/0", req_ready, mem_MemWrite); else pass++;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    do_reset();
    req_valid = 2'b01; req_rw = 2'b00; req_addr[31:0] = 32'h40;
    tick(); tick();
    total++; if (mem_MemRead !== 1'b1) $display("FAIL rbusy_pre: got %b expected 1", mem_MemRead); else pass++;
    iRST_n = 1'b0; req_valid = 2'b00; mem_ready = 1'b1;
    #1;
    total++; if (mem_MemRead !== 1'b0 || req_ready !== 2'b00) $display("FAIL rbusy_abort: got rd=%b rdy=%b expected 0/00", mem_MemRead, req_ready); else pass++;
    tick();
    total++; if (req_ready !== 2'b00) $display("FAIL rbusy_no_ready: got %b expected 00", req_ready); else pass++;
    iRST_n = 1'b1;
    tick();
    total++; if ({req_ready, mem_MemRead} !== 3'b000) $display("FAIL rbusy_idle: got %b expected 000", {req_ready, mem_MemRead}); else pass++;
    req_valid = 2'b01; mem_rdata = 32'h5A5A0001;
    tick(); tick();
    total++; if (req_ready !== 2'b01 || req_rdata !== 32'h5A5A0001) $display("FAIL rbusy_after: got rdy=%b data=%h expected 01/5a5a0001", req_ready, req_rdata); else pass++;
    req_valid = 2'b00; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid = 2'b01; req_rw = 2'b00; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick(); tick();
    total++; if (req_ready !== 2'b01 || arb_timeout !== 1'b0 || req_rdata !== 32'hCAFEF00D) $display("FAIL to_normal: got rdy=%b to=%b data=%h expected 01/0/cafef00d", req_ready, arb_timeout, req_rdata); else pass++;
    mem_ready = 1'b0;
    tick();
    tick();
    req_valid = 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
    tick(); tick(); tick();
    total++; if (mem_MemRead !== 1'b1 || req_ready !== 2'b00) $display("FAIL to_busy4: got rd=%b rdy=%b expected 1/00", mem_MemRead, req_ready); else pass++;
    tick();
    total++; if (req_ready !== 2'b01 || arb_timeout !== 1'b1 || req_rdata !== 32'h0 || mem_MemRead !== 1'b0) $display("FAIL to_fire: got rdy=%b to=%b data=%h rd=%b expected 01/1/0/0", req_ready, arb_timeout, req_rdata, mem_MemRead); else pass++;
    tick();
    total++; if (arb_timeout !== 1'b0 || req_ready !== 2'b00) $display("FAIL to_pulse: got to=%b rdy=%b expected 0/00", arb_timeout, req_ready); else pass++;
`else
    for (int n = 0; n < 10; n++) tick();
    total++; if (mem_MemRead !== 1'b1 || req_ready !== 2'b00 || arb_timeout !== 1'b0) $display("FAIL to_off_wait: got rd=%b rdy=%b to=%b expected 1/00/0", mem_MemRead, req_ready, arb_timeout); else pass++;
    mem_ready = 1'b1; mem_rdata = 32'h0BADC0DE;
    tick();
    total++; if (req_ready !== 2'b01 || arb_timeout !== 1'b0 || req_rdata !== 32'h0BADC0DE) $display("FAIL to_off_done: got rdy=%b to=%b data=%h expected 01/0/0badc0de", req_ready, arb_timeout, req_rdata); else pass++;
    mem_ready = 1'b0;
    tick();
`endif
  endtask

  task automatic test_input_change();
    do_reset();
    req_valid = 2'b01; req_rw = 2'b00; req_addr[31:0] = 32'h40;
    tick();
    req_addr[31:0] = 32'h44; req_rw = 2'b01;
    tick();
    total++; if (mem_addr !== 32'h40 || mem_MemRead !== 1'b1 || mem_MemWrite !== 1'b0) $display("FAIL in_change: got addr=%h rd=%b wr=%b expected 40/1/0", mem_addr, mem_MemRead, mem_MemWrite); else pass++;
    mem_ready = 1'b1;
    tick();
    total++; if (req_ready !== 2'b01 || mem_addr !== 32'h40) $display("FAIL in_change_done: got rdy=%b addr=%h expected 01/40", req_ready, mem_addr); else pass++;
    req_valid = 2'b00; mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_wait();
    test_reset_busy();
    test_timeout();
    test_input_change();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
